// File: rtl/seq_multicycle_core.sv
// seq_multicycle_core
// Multi-cycle sequential processor control core. Each instruction walks
// FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PCUPD. MEMORY may be
// stretched by a memory handshake. Faults, bad status or a memory timeout park
// the core in HALT until reset.
//
// Ports
//   clk         single clock, rising-edge state updates
//   reset       asynchronous active-high reset
//   srcA/srcB   register read indices, sampled at the DECODE->EXECUTE edge
//   dstE/dstM   writeback indices, used in WRITEBACK (dstM wins on a clash)
//   valE/valM   ALU result / memory read data written back in WRITEBACK
//   next_pc     PC loaded at the end of PCUPD
//   dm_stat     memory/fetch status sampled when MEMORY completes
//   mem_access  current instruction uses the memory handshake
//   mem_ack     memory completion strobe, only honoured while mem_req=1
//   pc          current program counter
//   valA/valB   registered operands
//   mem_req     memory request, held until acknowledged or timed out
//   stage       FSM state encoding (0..6)
//   stat        processor status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   retire      one-cycle pulse while PCUPD is active
module seq_multicycle_core #(
    parameter int                DATA_W       = 64,
    parameter int                NREG         = 15,
    parameter logic [DATA_W-1:0] RESET_PC     = '0,
    parameter int                MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [DATA_W-1:0] next_pc,
    input  logic [2:0]        dm_stat,
    input  logic              mem_access,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              mem_req,
    output logic [2:0]        stage,
    output logic [2:0]        stat,
    output logic              retire
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_PCUPD     = 3'd5,
        ST_HALT      = 3'd6
    } stage_e;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    // Counter only needs to reach MEM_WAIT_MAX-1: the cycle that would make it
    // MEM_WAIT_MAX is the timeout cycle itself.
    localparam int              CNT_W     = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);
    localparam logic [4:0]      NREG_L    = 5'(NREG);

    stage_e              stage_q, stage_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   val_a_q, val_a_d;
    logic [DATA_W-1:0]   val_b_q, val_b_d;
    logic [2:0]          stat_q, stat_d;
    logic                mem_req_q, mem_req_d;
    logic                retire_q, retire_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0]   rf_q [NREG];
    logic [DATA_W-1:0]   rf_d [NREG];

    logic [DATA_W-1:0]   rd_a_s;
    logic [DATA_W-1:0]   rd_b_s;
    logic                mem_done_s;

    // Index 0xF is the "no register" encoding; indices past NREG do not exist.
    function automatic logic idx_ok(input logic [3:0] idx);
        return (idx != 4'hF) && ({1'b0, idx} < NREG_L);
    endfunction

    // Register-file read ports with out-of-range indices reading as zero.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        if (idx_ok(srcA)) begin
            rd_a_s = rf_q[srcA];
        end else begin
            rd_a_s = '0;
        end
        if (idx_ok(srcB)) begin
            rd_b_s = rf_q[srcB];
        end else begin
            rd_b_s = '0;
        end
    end

    // MEMORY is finished when no request is pending or the pending one is acked.
    assign mem_done_s = !mem_req_q || mem_ack;

    // Next-state and datapath update logic for the instruction sequencer.
    always_comb begin
        stage_d   = stage_q;
        pc_d      = pc_q;
        val_a_d   = val_a_q;
        val_b_d   = val_b_q;
        stat_d    = stat_q;
        mem_req_d = 1'b0;
        retire_d  = 1'b0;
        wait_d    = wait_q;
        rf_d      = rf_q;

        case (stage_q)
            ST_FETCH: begin
                stage_d = ST_DECODE;
            end
            ST_DECODE: begin
                val_a_d = rd_a_s;
                val_b_d = rd_b_s;
                stage_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Raise the request on entry so it is visible in the first MEMORY cycle.
                mem_req_d = mem_access;
                wait_d    = '0;
                stage_d   = ST_MEMORY;
            end
            ST_MEMORY: begin
                if (mem_done_s) begin
                    if (dm_stat != STAT_AOK) begin
                        stat_d  = dm_stat;
                        stage_d = ST_HALT;
                    end else begin
                        stage_d = ST_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    stat_d  = STAT_ADR;
                    stage_d = ST_HALT;
                end else begin
                    wait_d    = wait_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                // Every loop index is < NREG <= 15, so 0xF and out-of-range
                // destinations never match and are dropped naturally.
                for (int i = 0; i < NREG; i++) begin
                    if (dstM == 4'(i)) begin
                        rf_d[i] = valM;
                    end else if (dstE == 4'(i)) begin
                        rf_d[i] = valE;
                    end else begin
                        rf_d[i] = rf_q[i];
                    end
                end
                retire_d = 1'b1;
                stage_d  = ST_PCUPD;
            end
            ST_PCUPD: begin
                pc_d    = next_pc;
                stage_d = ST_FETCH;
            end
            ST_HALT: begin
                stage_d = ST_HALT;
            end
            default: begin
                stage_d = ST_HALT;
            end
        endcase
    end

    // State registers; reset forces the architectural start-up state at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            val_a_q   <= '0;
            val_b_q   <= '0;
            stat_q    <= STAT_AOK;
            mem_req_q <= 1'b0;
            retire_q  <= 1'b0;
            wait_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= DATA_W'(i);
            end
        end else begin
            stage_q   <= stage_d;
            pc_q      <= pc_d;
            val_a_q   <= val_a_d;
            val_b_q   <= val_b_d;
            stat_q    <= stat_d;
            mem_req_q <= mem_req_d;
            retire_q  <= retire_d;
            wait_q    <= wait_d;
            rf_q      <= rf_d;
        end
    end

    assign pc      = pc_q;
    assign valA    = val_a_q;
    assign valB    = val_b_q;
    assign mem_req = mem_req_q;
    assign stage   = stage_q;
    assign stat    = stat_q;
    assign retire  = retire_q;

endmodule

// File: tb/tb_seq_multicycle_core.sv
// Directed self-checking bench for seq_multicycle_core. Inputs are driven and
// outputs sampled on the falling clock edge. Cycle 1 of an instruction is the
// FETCH cycle.
module tb_seq_multicycle_core;

    localparam logic [63:0] RPC = 64'h0000_0000_0000_1000;

    logic        clk;
    logic        reset;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valE, valM, next_pc;
    logic [2:0]  dm_stat;
    logic        mem_access, mem_ack;
    logic [63:0] pc, valA, valB;
    logic        mem_req;
    logic [2:0]  stage, stat;
    logic        retire;

    int tests = 0;
    int fails = 0;
    int cyc;
    int cnt;

    seq_multicycle_core #(
        .DATA_W(64), .NREG(15), .RESET_PC(RPC), .MEM_WAIT_MAX(15)
    ) dut (
        .clk(clk), .reset(reset),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valE(valE), .valM(valM), .next_pc(next_pc),
        .dm_stat(dm_stat), .mem_access(mem_access), .mem_ack(mem_ack),
        .pc(pc), .valA(valA), .valB(valB), .mem_req(mem_req),
        .stage(stage), .stat(stat), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance until retire is seen; result is the cycle number within the instruction.
    task automatic run_to_retire(input int start, output int c);
        c = start;
        while (retire !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; srcA = 4'h0; srcB = 4'h0; dstE = 4'hF; dstM = 4'hF;
        valE = 64'h0; valM = 64'h0; next_pc = 64'h0; dm_stat = 3'd1;
        mem_access = 1'b0; mem_ack = 1'b0;
        step(2);
        chk("rst_stage",   64'(stage),   64'd0);
        chk("rst_pc",      pc,           RPC);
        chk("rst_stat",    64'(stat),    64'd1);
        chk("rst_valA",    valA,         64'd0);
        chk("rst_valB",    valB,         64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_retire",  64'(retire),  64'd0);
        reset = 1'b0;

        // Scenario 1: plain instruction, no memory access, stray ack ignored.
        srcA = 4'd2; srcB = 4'd3; next_pc = 64'h1008;
        step(1);
        chk("s1_decode", 64'(stage), 64'd1);
        step(1);
        chk("s1_execute", 64'(stage), 64'd2);
        chk("s1_valA", valA, 64'd2);
        chk("s1_valB", valB, 64'd3);
        mem_ack = 1'b1;
        step(1);
        chk("s1_memory", 64'(stage), 64'd3);
        chk("s1_no_req", 64'(mem_req), 64'd0);
        mem_ack = 1'b0;
        run_to_retire(4, cyc);
        chk("s1_retire_cycle", 64'(cyc), 64'd6);
        chk("s1_pc_before_upd", pc, RPC);
        step(1);
        chk("s1_fetch", 64'(stage), 64'd0);
        chk("s1_retire_once", 64'(retire), 64'd0);
        chk("s1_pc", pc, 64'h1008);

        // Scenario 2: same-index writeback, valM wins; reads see old value first.
        srcA = 4'd4; srcB = 4'hF; dstE = 4'd4; dstM = 4'd4;
        valE = 64'hAA; valM = 64'hBB; next_pc = 64'h1010;
        step(2);
        chk("s2_valA_old", valA, 64'd4);
        chk("s2_valB_f", valB, 64'd0);
        run_to_retire(3, cyc);
        chk("s2_retire_cycle", 64'(cyc), 64'd6);
        step(1);
        chk("s2_pc", pc, 64'h1010);

        // Read back reg4 and write distinct dstE/dstM targets.
        srcA = 4'd4; srcB = 4'd5; dstE = 4'd5; dstM = 4'd6;
        valE = 64'h55; valM = 64'h66; next_pc = 64'h1018;
        step(2);
        chk("s2_valA_bb", valA, 64'hBB);
        chk("s2_valB_5", valB, 64'd5);
        run_to_retire(3, cyc);
        step(1);
        srcA = 4'd5; srcB = 4'd6; dstE = 4'hF; dstM = 4'hF;
        valE = 64'hDEAD; valM = 64'hBEEF; next_pc = 64'h1020;
        step(2);
        chk("s2_valA_e", valA, 64'h55);
        chk("s2_valB_m", valB, 64'h66);
        run_to_retire(3, cyc);
        step(1);

        // Scenario 3: memory access acked on the 4th MEMORY cycle (3 wait cycles).
        srcA = 4'd0; srcB = 4'd1; mem_access = 1'b1; next_pc = 64'h1028;
        step(1);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        chk("s3_exec_no_req", 64'(mem_req), 64'd0);
        step(1);
        chk("s3_mem_stage", 64'(stage), 64'd3);
        chk("s3_req_c4", 64'(mem_req), 64'd1);
        step(2);
        chk("s3_req_c6", 64'(mem_req), 64'd1);
        step(1);
        chk("s3_stage_c7", 64'(stage), 64'd3);
        chk("s3_req_c7", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        chk("s3_wb_stage", 64'(stage), 64'd4);
        chk("s3_req_drop", 64'(mem_req), 64'd0);
        step(1);
        chk("s3_retire_c9", 64'(retire), 64'd1);
        step(1);
        chk("s3_pc", pc, 64'h1028);
        mem_access = 1'b0;

        // Scenario 6: index 0xF reads zero and writes nothing.
        srcA = 4'hF; srcB = 4'd4; dstE = 4'hF; dstM = 4'hF;
        valE = 64'hDEAD; valM = 64'hDEAD; next_pc = 64'h1030;
        step(2);
        chk("s6_valA", valA, 64'd0);
        chk("s6_valB", valB, 64'hBB);
        run_to_retire(3, cyc);
        chk("s6_retire_cycle", 64'(cyc), 64'd6);
        step(1);
        srcA = 4'd14; srcB = 4'd1; next_pc = 64'h1038;
        step(2);
        chk("s6_reg14", valA, 64'd14);
        chk("s6_reg1", valB, 64'd1);
        run_to_retire(3, cyc);
        step(1);

        // Scenario 5: bad dm_stat at end of MEMORY halts without retire.
        dstE = 4'd1; valE = 64'h77; dm_stat = 3'd2; next_pc = 64'h2000;
        step(4);
        chk("s5_halt", 64'(stage), 64'd6);
        chk("s5_stat", 64'(stat), 64'd2);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (retire === 1'b1) cnt++;
        end
        chk("s5_no_retire", 64'(cnt), 64'd0);
        chk("s5_still_halt", 64'(stage), 64'd6);
        chk("s5_pc_hold", pc, 64'h1038);
        chk("s5_stat_hold", 64'(stat), 64'd2);
        dm_stat = 3'd1;
        reset = 1'b1;
        #1;
        chk("s5_rst_stat", 64'(stat), 64'd1);
        chk("s5_rst_pc", pc, RPC);
        chk("s5_rst_stage", 64'(stage), 64'd0);
        step(1);
        reset = 1'b0; dstE = 4'hF;

        // Scenario 4: no ack ever -> timeout after 15 wait cycles.
        srcA = 4'd4; srcB = 4'd1; mem_access = 1'b1; next_pc = 64'h3000;
        step(2);
        chk("s4_reg4_restored", valA, 64'd4);
        chk("s4_reg1", valB, 64'd1);
        cyc = 3; cnt = 0;
        while (stage !== 3'd6 && cyc < 60) begin
            step(1);
            cyc++;
            if (mem_req === 1'b1) cnt++;
        end
        chk("s4_req_cycles", 64'(cnt), 64'd15);
        chk("s4_halt_cycle", 64'(cyc), 64'd19);
        chk("s4_stat", 64'(stat), 64'd3);
        chk("s4_pc", pc, RPC);
        chk("s4_req_drop", 64'(mem_req), 64'd0);
        mem_ack = 1'b1;
        step(2);
        mem_ack = 1'b0;
        chk("s4_absorb_stage", 64'(stage), 64'd6);
        chk("s4_absorb_stat", 64'(stat), 64'd3);
        chk("s4_absorb_req", 64'(mem_req), 64'd0);

        // Reset during an outstanding memory request.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(4);
        chk("rm_req_up", 64'(mem_req), 64'd1);
        chk("rm_stage", 64'(stage), 64'd3);
        reset = 1'b1;
        #1;
        chk("rm_req_async_drop", 64'(mem_req), 64'd0);
        chk("rm_stage_fetch", 64'(stage), 64'd0);
        mem_ack = 1'b1;
        step(1);
        reset = 1'b0; mem_access = 1'b0;
        step(1);
        mem_ack = 1'b0;
        chk("rm_decode", 64'(stage), 64'd1);
        chk("rm_no_req", 64'(mem_req), 64'd0);
        run_to_retire(2, cyc);
        chk("rm_retire_cycle", 64'(cyc), 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
